uart_rx_param: RTL

//  Parametrised UART receiver; successor to the fixed 8N1 receiver in UART_top.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_baud_tick.sv | 33 +++
 rtl/uart_rx_param.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and helpers: receiver state encoding, parity modes and
// the oversampling clock divider calculation.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // Rounded divide so the oversample rate lands as close to BAUD*OS as possible.
  function automatic int calc_div(input int clk_hz, input int baud, input int os);
    longint den;
    den = longint'(baud) * longint'(os);
    return int'((longint'(clk_hz) + den / 2) / den);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick generator: one-clock pulse every DIV clocks.
// Shared between the UART receiver and transmitter.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;
  logic          wrap;

  assign wrap = (cnt == CW'(DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= wrap;
      cnt  <= wrap ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver with parity/framing error reporting.
// Optional feature macro UART_RX_MAJORITY_EN: 2-of-3 vote around the bit centre.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLK_FREQ    = 100_000_000,
  parameter int BAUD_RATE   = 9600,
  parameter int OVERSAMPLE  = 16,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 rx_busy
);

  localparam int MID = OVERSAMPLE / 2 - 1;
  localparam int SW  = $clog2(OVERSAMPLE);
`ifdef UART_RX_MAJORITY_EN
  localparam int DEC = MID + 1;
`else
  localparam int DEC = MID;
`endif

  logic                 rx_p0, rxs;
  logic                 tick;
  rx_state_t            state_q, state_d;
  logic [SW-1:0]        samp_cnt;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 ferr_acc, perr_acc, brk_wait;
  logic                 smp, sample_now, data_last, stop_last;

  uart_baud_tick #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  // Stage p0 -> rxs: two-flop synchroniser, idles high
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_p0 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      rx_p0 <= rx;
      rxs   <= rx_p0;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist;

  function automatic logic maj3(input logic [2:0] s);
    return (s[2] & s[1]) | (s[2] & s[0]) | (s[1] & s[0]);
  endfunction

  // hist holds the samples from ticks MID-1 and MID when the vote is taken at MID+1
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      hist <= 2'b11;
    else if (tick) hist <= {hist[0], rxs};
  end

  assign smp = maj3({hist, rxs});
`else
  assign smp = rxs;
`endif

  assign sample_now = tick && (samp_cnt == SW'(DEC));
  assign data_last  = (bit_cnt == 4'(DATA_BITS - 1));
  assign stop_last  = (bit_cnt == 4'(STOP_BITS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!rxs && !brk_wait) state_d = START;
      START:   if (sample_now) state_d = smp ? IDLE : DATA;
      DATA:    if (sample_now && data_last)
                 state_d = (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
      PARITY:  if (sample_now) state_d = STOP;
      STOP:    if (sample_now && stop_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Sample phase restarts at the start edge so every bit is read near its centre
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  samp_cnt <= '0;
    else if (state_q == IDLE)  samp_cnt <= '0;
    else if (tick)
      samp_cnt <= (samp_cnt == SW'(OVERSAMPLE - 1)) ? '0 : samp_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (state_q == DATA && sample_now) shreg <= {smp, shreg[DATA_BITS-1:1]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt    <= '0;
      ferr_acc   <= 1'b0;
      perr_acc   <= 1'b0;
      brk_wait   <= 1'b0;
      rx_data    <= '0;
      rx_done    <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      rx_busy    <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      rx_busy <= (state_d != IDLE);
      case (state_q)
        IDLE: begin
          bit_cnt  <= '0;
          ferr_acc <= 1'b0;
          perr_acc <= 1'b0;
          if (rxs) brk_wait <= 1'b0;
        end
        START: bit_cnt <= '0;
        DATA: if (sample_now) bit_cnt <= data_last ? '0 : bit_cnt + 1'b1;
        PARITY: if (sample_now)
          perr_acc <= ((^shreg) ^ smp) != (PARITY_MODE == PARITY_ODD);
        STOP: if (sample_now) begin
          if (stop_last) begin
            // A low stop bit arms the break guard so a held-low line reports once
            rx_data    <= shreg;
            rx_done    <= 1'b1;
            frame_err  <= ferr_acc | ~smp;
            parity_err <= perr_acc;
            brk_wait   <= ferr_acc | ~smp;
            bit_cnt    <= '0;
          end else begin
            ferr_acc <= ferr_acc | ~smp;
            bit_cnt  <= bit_cnt + 1'b1;
          end
        end
        default: bit_cnt <= '0;
      endcase
    end
  end

endmodule
